// File: rtl/clock_bank.sv
// clock_bank: bank of prescaled counters with carry chaining, saturation, overflow flags and a compare-query pipeline
module clock_bank #(
    parameter int N_CLK = 8,
    parameter int CNT_W = 12,
    parameter int DIV_W = 10,
    localparam int IDX_W = $clog2(N_CLK)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [N_CLK-1:0]         cfg_join,
    input  logic [N_CLK-1:0]         cfg_sat,
    input  logic [N_CLK*DIV_W-1:0]   cfg_div,
    input  logic [N_CLK-1:0]         clr,
    input  logic                     load_valid,
    input  logic [IDX_W-1:0]         load_idx,
    input  logic [CNT_W-1:0]         load_val,
    input  logic                     q_valid,
    input  logic [IDX_W-1:0]         q_idx,
    input  logic [1:0]               q_op,
    input  logic [CNT_W-1:0]         q_imm,
    output logic                     r_valid,
    output logic                     r_val,
    output logic [CNT_W-1:0]         r_count,
    output logic [N_CLK-1:0]         ovf,
    input  logic [N_CLK-1:0]         ovf_clr,
    output logic [N_CLK*CNT_W-1:0]   counters
);
    localparam logic [IDX_W:0] NC = IDX_W'(N_CLK) == '0 ? {1'b1, {IDX_W{1'b0}}} : {1'b0, IDX_W'(N_CLK)};

    logic [CNT_W-1:0] count [N_CLK];
    logic [DIV_W-1:0] pre [N_CLK];
    logic [N_CLK-1:0] tick, inc, ld;
    logic             s1_valid, s1_bad, cmp;
    logic [1:0]       s1_op;
    logic [CNT_W-1:0] s1_cnt, s1_imm;

    // walk the carry ring starting at the lowest unjoined clock so no combinational loop exists
    always_comb begin : chain
        logic [IDX_W-1:0] s, i;
        logic c;
        s = '0;
        i = '0;
        c = 1'b0;
        inc = '0;
        for (int k = 0; k < N_CLK; k++) tick[k] = pre[k] == '0;
        for (int k = N_CLK - 1; k >= 0; k--) if (!cfg_join[k]) s = IDX_W'(k);
        for (int k = 0; k < N_CLK; k++) begin
            i = IDX_W'((int'(s) + k) % N_CLK);
            inc[i] = en & ((k != 0 && cfg_join[i]) ? c : tick[i]);
            c = inc[i] & (&count[i]) & ~cfg_sat[i];
        end
    end

    // one-hot load target; indices beyond the bank shift out and select nothing
    always_comb ld = load_valid ? (N_CLK'(1) << load_idx) : '0;

    // per-clock counter, prescaler and sticky overflow state
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_CLK; i++) begin
            if (!reset) begin
                count[i] <= '0;
                pre[i]   <= '0;
                ovf[i]   <= 1'b0;
            end else begin
                ovf[i] <= (ovf[i] & ~ovf_clr[i]) | (inc[i] & (&count[i]) & ~clr[i] & ~ld[i]);
                if (clr[i]) begin
                    count[i] <= '0;
                    pre[i]   <= '0;
                end else begin
                    if (en) pre[i] <= tick[i] ? cfg_div[DIV_W*i +: DIV_W] : pre[i] - 1'b1;
                    if (ld[i]) count[i] <= load_val;
                    else if (inc[i]) count[i] <= ((&count[i]) && cfg_sat[i]) ? count[i] : count[i] + 1'b1;
                end
            end
        end
    end

    // unsigned comparison selected by the registered opcode
    always_comb cmp = s1_op == 2'd0 ? s1_cnt == s1_imm :
                      s1_op == 2'd1 ? s1_cnt <  s1_imm :
                      s1_op == 2'd2 ? s1_cnt >= s1_imm :
                                      s1_cnt != s1_imm;

    // two-stage query pipeline sampling the pre-update count
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            r_valid  <= 1'b0;
            r_val    <= 1'b0;
            r_count  <= '0;
        end else begin
            s1_valid <= q_valid;
            r_valid  <= s1_valid;
            if (q_valid) begin
                s1_bad <= {1'b0, q_idx} >= NC;
                s1_cnt <= count[q_idx];
                s1_op  <= q_op;
                s1_imm <= q_imm;
            end
            if (s1_valid) begin
                r_val   <= ~s1_bad & cmp;
                r_count <= s1_bad ? '0 : s1_cnt;
            end
        end
    end

    // flatten live counts onto the output bus
    always_comb begin
        counters = '0;
        for (int i = 0; i < N_CLK; i++) counters[CNT_W*i +: CNT_W] = count[i];
    end
endmodule

// File: tb/tb_clock_bank.sv
// tb_clock_bank: directed scoreboard bench for clock_bank
module tb_clock_bank;
    localparam int N = 6;
    localparam int C = 12;
    localparam int D = 4;

    logic           clk = 1'b0;
    logic           reset, en, load_valid, q_valid;
    logic [N-1:0]   cfg_join, cfg_sat, clr, ovf_clr, ovf;
    logic [N*D-1:0] cfg_div;
    logic [2:0]     load_idx, q_idx;
    logic [C-1:0]   load_val, q_imm, r_count;
    logic [1:0]     q_op;
    logic           r_valid, r_val;
    logic [N*C-1:0] counters;

    typedef struct {logic v; logic [C-1:0] c; int t;} exp_t;
    exp_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    clock_bank #(.N_CLK(N), .CNT_W(C), .DIV_W(D)) dut (
        .clk(clk), .reset(reset), .en(en), .cfg_join(cfg_join), .cfg_sat(cfg_sat),
        .cfg_div(cfg_div), .clr(clr), .load_valid(load_valid), .load_idx(load_idx),
        .load_val(load_val), .q_valid(q_valid), .q_idx(q_idx), .q_op(q_op), .q_imm(q_imm),
        .r_valid(r_valid), .r_val(r_val), .r_count(r_count), .ovf(ovf), .ovf_clr(ovf_clr),
        .counters(counters)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, a, e);
        end
    endtask

    function automatic logic [C-1:0] cnt(input int i);
        return C'(counters >> (C * i));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        q_valid    = 1'b0;
        clr        = '0;
        ovf_clr    = '0;
    endtask

    task automatic load(input logic [2:0] i, input logic [C-1:0] v);
        load_valid = 1'b1;
        load_idx   = i;
        load_val   = v;
    endtask

    task automatic query(input logic [2:0] i, input logic [1:0] op, input logic [C-1:0] imm,
                         input logic ev, input logic [C-1:0] ec);
        q_valid = 1'b1;
        q_idx   = i;
        q_op    = op;
        q_imm   = imm;
        sb.push_back('{ev, ec, cyc + 2});
    endtask

    // monitor: every presented result must match the oldest expectation and its issue latency
    always @(negedge clk) begin
        if (r_valid === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL r_valid_unexpected got=1 exp=0");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("r_val", 32'(r_val), 32'(e.v));
                chk("r_count", 32'(r_count), 32'(e.c));
                chk("r_latency", cyc, e.t);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b1; cfg_join = '0; cfg_sat = '0; clr = '0; ovf_clr = '0;
        cfg_div = {4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd3};
        load_valid = 1'b0; load_idx = '0; load_val = '0;
        q_valid = 1'b0; q_idx = '0; q_op = '0; q_imm = '0;
        step(); step();
        for (int i = 0; i < N; i++) chk("rst_count", 32'(cnt(i)), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_r_valid", 32'(r_valid), 0);

        reset = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("div3_count0", 32'(cnt(0)), (k + 3) / 4);
            chk("div0_count1", 32'(cnt(1)), k);
        end
        en = 1'b0;

        cfg_join = 6'b000010;
        cfg_div = {4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd0};
        clr = 6'b000011; step();
        load(0, 12'hFFF); step();
        en = 1'b1; step(); en = 1'b0;
        chk("wrap_count0", 32'(cnt(0)), 0);
        chk("wrap_carry_count1", 32'(cnt(1)), 1);
        chk("wrap_ovf", 32'(ovf), 32'h1);
        ovf_clr = 6'b000001; step();
        chk("ovf_clr", 32'(ovf), 0);
        cfg_sat = 6'b000001;
        load(0, 12'hFFF); step();
        en = 1'b1; step(); en = 1'b0;
        chk("sat_count0", 32'(cnt(0)), 32'hFFF);
        chk("sat_no_carry_count1", 32'(cnt(1)), 1);
        chk("sat_ovf", 32'(ovf), 32'h1);
        ovf_clr = 6'b000001; en = 1'b1; step(); en = 1'b0;
        chk("ovf_set_wins", 32'(ovf), 32'h1);
        ovf_clr = 6'b000001; step();
        chk("ovf_clr2", 32'(ovf), 0);

        load(2, 12'h123); clr = 6'b000100; step();
        chk("clr_over_load", 32'(cnt(2)), 0);
        load(2, 12'h123); step();
        chk("load", 32'(cnt(2)), 32'h123);

        load(1, 12'd5); step();
        query(1, 2'd0, 12'd5, 1'b1, 12'd5); step();
        query(1, 2'd1, 12'd5, 1'b0, 12'd5); step();
        query(3'd6, 2'd0, 12'd0, 1'b0, 12'd0); step();
        query(2, 2'd2, 12'h100, 1'b1, 12'h123); step();
        query(0, 2'd3, 12'hFFF, 1'b0, 12'hFFF); step();
        query(1, 2'd0, 12'd5, 1'b1, 12'd5); load(1, 12'd7); step();
        chk("load_after_query", 32'(cnt(1)), 7);
        for (int k = 0; k < 10 && sb.size() > 0; k++) step();
        chk("sb_drain", sb.size(), 0);

        en = 1'b1; step(); en = 1'b0;
        chk("ovf_before_reset", 32'(ovf), 32'h1);
        q_valid = 1'b1; q_idx = 0; q_op = 2'd0; q_imm = 12'hFFF; step();
        reset = 1'b0; load(3, 12'h55); clr = '0; step(); reset = 1'b1;
        for (int i = 0; i < N; i++) chk("midrst_count", 32'(cnt(i)), 0);
        chk("midrst_ovf", 32'(ovf), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("midrst_r_valid", 32'(r_valid), 0);
        end

        cfg_join = 6'b111111; cfg_sat = '0; cfg_div = '0;
        for (int i = 0; i < 5; i++) begin
            load(3'(i), 12'hFFF); step();
        end
        en = 1'b1; step(); en = 1'b0;
        for (int i = 0; i < 5; i++) chk("ring_wrap_count", 32'(cnt(i)), 0);
        chk("ring_count5", 32'(cnt(5)), 1);
        chk("ring_ovf", 32'(ovf), 32'h1F);
        en = 1'b1; step(); en = 1'b0;
        chk("ring_self_tick_count0", 32'(cnt(0)), 1);
        chk("ring_hold_count1", 32'(cnt(1)), 0);
        chk("ring_hold_count5", 32'(cnt(5)), 1);
        chk("sb_final", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
